sample_packer: RTL and testbench

Packs per-cycle quantized or raw ADC samples into 16-bit words. Emits packet-end marks on fixed word-count boundaries. Sits between the quantizer/gray-decode stage and `packet_streamer`, and drives that block's `source_data`/`source_en`/`source_packet_end` inputs. The mode register lives in the CPU clock domain; changes are synchronized here and applied only on packet boundaries.

---
 rtl/sample_packer_pkg.sv | 35 +++
 rtl/sample_packer_mode_sync.sv | 40 ++++
 rtl/sample_packer.sv | 184 ++++++++++++++++++
 tb/tb_sample_packer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_packer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sample_packer_pkg                                                      |
// | Shared constants, state encoding and mode decoding for sample_packer.  |
// | Macro: SAMPLE_PACKER_TEST_PATTERN_EN adds MODE_TEST to the supported    |
// |        mode set.                                                       |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package sample_packer_pkg;

  localparam logic [7:0] MODE_QUANT = 8'h00;
  localparam logic [7:0] MODE_CH1_I = 8'h01;
  localparam logic [7:0] MODE_CH1_Q = 8'h02;
  localparam logic [7:0] MODE_TEST  = 8'hFF;
  localparam logic [7:0] MODE_NONE  = 8'h80;

  localparam int ACC_W = 28;  // pending bits, left-aligned (oldest in MSB)
  localparam int WC_W  = 12;  // word counter, covers packets up to 4095 words

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic mode_supported(input logic [7:0] m);
    logic ok;
    ok = (m == MODE_QUANT) || (m == MODE_CH1_I) || (m == MODE_CH1_Q);
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
    ok = ok || (m == MODE_TEST);
`endif
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_packer_mode_sync.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mode_sync                                                              |
// | Brings the CPU-domain mode register into the sample clock domain:      |
// | two flops per bit, then a filter that only passes a value once two     |
// | consecutive synchronized samples agree (guards against multi-bit skew).|
// | Ports: clk, rst_n (async, active low), async_mode[7:0] in,             |
// |        synced_mode[7:0] out.                                           |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module mode_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] async_mode,
  output logic [7:0] synced_mode
);
  import sample_packer_pkg::*;

  logic [7:0] meta;
  logic [7:0] stable;
  logic [7:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta        <= MODE_NONE;
      stable      <= MODE_NONE;
      prev        <= MODE_NONE;
      synced_mode <= MODE_NONE;
    end else begin
      meta   <= async_mode;
      stable <= meta;
      prev   <= stable;
      if (stable == prev) begin
        synced_mode <= stable;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sample_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sample_packer                                                          |
// | Packs quantized (12-bit) or raw ch1 I/Q (8-bit) samples into 16-bit    |
// | words with packet-end marks every WORDS_PER_PACKET words. Mode changes |
// | are synchronized and applied only at packet boundaries.                |
// | Ports: source_clk, source_reset_n (async, active low), mode[7:0],      |
// |        ch{1,2,3}_s{i,q}[1:0], ch1_i/ch1_q[7:0] in;                     |
// |        source_data[15:0], source_en, source_packet_end,                |
// |        active_mode[7:0] out.                                           |
// | Macro: SAMPLE_PACKER_TEST_PATTERN_EN enables mode 8'hFF (counter).     |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter int WORDS_PER_PACKET = 720
) (
  input  logic        source_clk,
  input  logic        source_reset_n,
  input  logic [7:0]  mode,
  input  logic [1:0]  ch1_si,
  input  logic [1:0]  ch1_sq,
  input  logic [1:0]  ch2_si,
  input  logic [1:0]  ch2_sq,
  input  logic [1:0]  ch3_si,
  input  logic [1:0]  ch3_sq,
  input  logic [7:0]  ch1_i,
  input  logic [7:0]  ch1_q,
  output logic [15:0] source_data,
  output logic        source_en,
  output logic        source_packet_end,
  output logic [7:0]  active_mode
);

  localparam logic [WC_W-1:0] LAST_WORD = 12'(WORDS_PER_PACKET - 1);

  logic [11:0]      quant_smp;
  logic [7:0]       ch1_i_smp;
  logic [7:0]       ch1_q_smp;
  logic [7:0]       synced_mode;
  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [4:0]       cnt;
  logic [WC_W-1:0]  word_cnt;
  logic             pending;
  logic [4:0]       k;
  logic [11:0]      bits;
  logic [4:0]       total;
  logic [4:0]       shamt;
  logic [ACC_W-1:0] merged;
  logic [15:0]      word;
  logic             emit;
  logic             last;
  logic             switch_now;
  logic             new_ok;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
  logic [15:0]      test_cnt;
`endif

  mode_sync u_mode_sync (
    .clk         (source_clk),
    .rst_n       (source_reset_n),
    .async_mode  (mode),
    .synced_mode (synced_mode)
  );

  // Sample width and payload for the mode currently applied.
  always_comb begin
    k    = 5'd0;
    bits = 12'd0;
    case (active_mode)
      MODE_QUANT: begin k = 5'd12; bits = quant_smp;          end
      MODE_CH1_I: begin k = 5'd8;  bits = {4'd0, ch1_i_smp};  end
      MODE_CH1_Q: begin k = 5'd8;  bits = {4'd0, ch1_q_smp};  end
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
      // Counter mode reuses the 8-bit cadence to get one word per 2 cycles.
      MODE_TEST:  begin k = 5'd8;  bits = 12'd0;              end
`endif
      default:    begin k = 5'd0;  bits = 12'd0;              end
    endcase
  end

  // New sample lands directly below the cnt pending bits (cnt+k <= 24).
  assign total  = cnt + k;
  assign shamt  = 5'd28 - total;
  assign merged = acc | ({16'd0, bits} << shamt);
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
  assign word   = (active_mode == MODE_TEST) ? test_cnt : merged[ACC_W-1 -: 16];
`else
  assign word   = merged[ACC_W-1 -: 16];
`endif
  assign emit       = (state == RUN) && (total >= 5'd16);
  assign last       = emit && (word_cnt == LAST_WORD);
  // Uses the registered pending flag: a change seen this very cycle waits.
  assign switch_now = last && pending;
  assign new_ok     = mode_supported(synced_mode);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (new_ok) state_next = RUN;
      RUN:     if (switch_now && !new_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge source_clk or negedge source_reset_n) begin
    if (!source_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge source_clk or negedge source_reset_n) begin
    if (!source_reset_n) begin
      quant_smp         <= 12'd0;
      ch1_i_smp         <= 8'd0;
      ch1_q_smp         <= 8'd0;
      acc               <= '0;
      cnt               <= 5'd0;
      word_cnt          <= '0;
      pending           <= 1'b0;
      active_mode       <= MODE_NONE;
      source_data       <= 16'd0;
      source_en         <= 1'b0;
      source_packet_end <= 1'b0;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
      test_cnt          <= 16'd0;
`endif
    end else begin
      quant_smp         <= {ch1_si, ch1_sq, ch2_si, ch2_sq, ch3_si, ch3_sq};
      ch1_i_smp         <= ch1_i;
      ch1_q_smp         <= ch1_q;
      source_data       <= 16'd0;
      source_en         <= 1'b0;
      source_packet_end <= 1'b0;
      if (state == IDLE) begin
        acc      <= '0;
        cnt      <= 5'd0;
        word_cnt <= '0;
        pending  <= 1'b0;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
        test_cnt <= 16'd0;
`endif
        if (new_ok) begin
          active_mode <= synced_mode;
        end
      end else begin
        if (synced_mode != active_mode) begin
          pending <= 1'b1;
        end
        if (emit) begin
          source_data       <= word;
          source_en         <= 1'b1;
          source_packet_end <= last;
          acc               <= merged << 16;
          cnt               <= total - 5'd16;
          word_cnt          <= last ? '0 : word_cnt + 12'd1;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
          test_cnt          <= test_cnt + 16'd1;
`endif
        end else begin
          acc <= merged;
          cnt <= total;
        end
        // Packet boundary with a queued change: drop residual bits, restart.
        if (switch_now) begin
          acc         <= '0;
          cnt         <= 5'd0;
          pending     <= 1'b0;
          active_mode <= synced_mode;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
          test_cnt    <= 16'd0;
`endif
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sample_packer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_sample_packer                                                       |
// | Self-checking bench: bit-queue reference model compared every cycle,   |
// | plus hand-computed expectations for each scenario.                     |
// | Macro: SAMPLE_PACKER_TEST_PATTERN_EN selects the test-pattern scenario.|
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_sample_packer;

  localparam int WPP = 720;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  mode = 8'h00;
  logic [1:0]  c1si = 2'b00, c1sq = 2'b00, c2si = 2'b00, c2sq = 2'b00, c3si = 2'b00, c3sq = 2'b00;
  logic [7:0]  c1i = 8'h00, c1q = 8'h00;
  logic [15:0] data;
  logic        en, pe;
  logic [7:0]  amode;
  int          smode = 0;  // 0: constant pattern, 1: ch1_i ramp, 2: random
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  sample_packer #(.WORDS_PER_PACKET(WPP)) dut (
    .source_clk        (clk),
    .source_reset_n    (rst_n),
    .mode              (mode),
    .ch1_si            (c1si),
    .ch1_sq            (c1sq),
    .ch2_si            (c2si),
    .ch2_sq            (c2sq),
    .ch3_si            (c3si),
    .ch3_sq            (c3sq),
    .ch1_i             (c1i),
    .ch1_q             (c1q),
    .source_data       (data),
    .source_en         (en),
    .source_packet_end (pe),
    .active_mode       (amode)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit supp(input logic [7:0] m);
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
    return (m == 8'h00) || (m == 8'h01) || (m == 8'h02) || (m == 8'hFF);
`else
    return (m == 8'h00) || (m == 8'h01) || (m == 8'h02);
`endif
  endfunction

  // Sample driver, away from the rising edge.
  always @(negedge clk) begin
    #1;
    case (smode)
      0: {c1si, c1sq, c2si, c2sq, c3si, c3sq} = 12'b01_10_11_00_01_10;
      1: c1i = c1i + 8'd1;
      default: begin
        {c1si, c1sq, c2si, c2sq, c3si, c3sq} = 12'($urandom);
        c1i = 8'($urandom);
        c1q = 8'($urandom);
      end
    endcase
  end

  // ---------------- reference model ----------------
  bit          q[$];
  bit          m_run, m_pend, old_pend, m_last;
  logic [7:0]  m_act, m_sync, sy;
  logic [7:0]  mh[3];          // sampled mode history, [0] newest
  logic [11:0] s_q12;
  logic [7:0]  s_i, s_q;
  int          m_wc, kbits;
  logic [15:0] m_t, w, e_data;
  logic [11:0] v;
  logic        e_en, e_pe;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_run = 0; m_pend = 0; m_act = 8'h80; m_sync = 8'h80;
      mh[0] = 8'h80; mh[1] = 8'h80; mh[2] = 8'h80;
      s_q12 = 0; s_i = 0; s_q = 0; m_wc = 0; m_t = 0;
      e_data = 0; e_en = 0; e_pe = 0;
    end else begin
      sy = m_sync;
      e_en = 0; e_pe = 0; e_data = 0; m_last = 0;
      if (!m_run) begin
        q.delete(); m_wc = 0; m_pend = 0; m_t = 0;
        if (supp(sy)) begin m_act = sy; m_run = 1; end
      end else begin
        old_pend = m_pend;
        if (sy != m_act) m_pend = 1;
        case (m_act)
          8'h00:   begin kbits = 12; v = s_q12; end
          8'h01:   begin kbits = 8;  v = {4'd0, s_i}; end
          8'h02:   begin kbits = 8;  v = {4'd0, s_q}; end
          default: begin kbits = 8;  v = 12'd0; end  // counter pattern cadence
        endcase
        for (int b = kbits - 1; b >= 0; b--) q.push_back(v[b]);
        if (q.size() >= 16) begin
          w = 0;
          for (int b = 0; b < 16; b++) w = {w[14:0], q.pop_front()};
          if (m_act == 8'hFF) begin w = m_t; m_t = m_t + 1; end
          m_last = (m_wc == WPP - 1);
          m_wc = m_last ? 0 : m_wc + 1;
          e_en = 1; e_pe = m_last; e_data = w;
        end
        if (m_last && old_pend) begin
          q.delete(); m_pend = 0; m_act = sy; m_run = supp(sy); m_t = 0;
        end
      end
      if (mh[1] == mh[2]) m_sync = mh[1];
      mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = mode;
      s_q12 = {c1si, c1sq, c2si, c2sq, c3si, c3sq}; s_i = c1i; s_q = c1q;
    end
  end

  always @(negedge clk) begin
    if (rst_n) chk("cycle", {6'd0, data, en, pe, amode}, {6'd0, e_data, e_en, e_pe, m_act});
  end

  // ---------------- scenario helpers ----------------
  task automatic run_to_pe(input int budget, output int words, output logic [15:0] last_w);
    bit ok;
    words = 0; last_w = 0; ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (en) begin
        words++;
        if (pe) begin last_w = data; ok = 1; end
      end
    end
    if (!ok) chk("pe_timeout", 0, 1);
  endtask

  task automatic count_words(input int n, input int budget);
    int got;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (en) got++;
    end
    chk("count_words", got, n);
  endtask

  task automatic gap_to_en(input int budget, output int gap);
    gap = -1;
    for (int c = 1; c <= budget && gap < 0; c++) begin
      @(negedge clk);
      if (en) gap = c;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          words, cyc, win, gap, idle_en;
    logic [15:0] w3[3];
    logic [15:0] lw;
    logic [7:0]  hi1;

    // Reset state.
    mode = 8'h00; smode = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {15'd0, data, en, pe}, 0);
    chk("reset_amode", amode, 8'h80);
    #2 rst_n = 1'b1;

    // Mode 0 packing: fixed words, 6 words per 8 cycles, packet end on 720th.
    words = 0; cyc = -1; win = 0; lw = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (cyc >= 0) cyc++;
      if (en) begin
        if (words < 3) w3[words] = data;
        if (words == 0) cyc = 0;
        words++;
      end
      if (en && cyc >= 0 && cyc < 8) win++;
      if (en && pe) break;
    end
    chk("m0_word0", w3[0], 16'h6C66);
    chk("m0_word1", w3[1], 16'hC66C);
    chk("m0_word2", w3[2], 16'h66C6);
    chk("m0_rate", win, 6);
    chk("m0_pe_index", words, WPP);

    // Mode change 0 -> 2 at word 100 of the next packet.
    count_words(100, 400);
    mode = 8'h02; smode = 2;
    run_to_pe(3000, words, lw);
    chk("chg_remaining", words, WPP - 100);
    gap_to_en(10, gap);
    chk("chg_gap", gap, 2);
    chk("chg_amode", amode, 8'h02);

    // Mode 1 byte order with ramp.
    mode = 8'h01; smode = 1;
    run_to_pe(3000, words, lw);
    for (int n = 0; n < 10; n++) begin
      gap_to_en(10, gap);
      chk("m1_gap", gap, 2);
      hi1 = data[15:8] + 8'd1;
      chk("m1_bytes", data[7:0], hi1);
    end

    // Unsupported mode.
    mode = 8'h07; smode = 2;
    run_to_pe(3000, words, lw);
    idle_en = 0;
    repeat (100) begin @(negedge clk); if (en) idle_en++; end
    chk("unsup_en", idle_en, 0);
    chk("unsup_amode", amode, 8'h07);
    mode = 8'h01;
    gap_to_en(30, gap);
    chk("resume_found", (gap > 0), 1);
    chk("resume_amode", amode, 8'h01);

    // Reset mid-packet.
    mode = 8'h00;
    count_words(300, 1000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {15'd0, data, en, pe}, 0);
    chk("rst_async_amode", amode, 8'h80);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    run_to_pe(3000, words, lw);
    chk("rst_restart_pe", words, WPP);

    // Test pattern mode.
    mode = 8'hFF;
    run_to_pe(3000, words, lw);
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
    for (int n = 0; n < 3; n++) begin
      gap_to_en(10, gap);
      chk("tp_word", data, n);
    end
    run_to_pe(3000, words, lw);
    chk("tp_pe_index", words, WPP - 3);
    chk("tp_pe_value", lw, 16'd719);
`else
    idle_en = 0;
    repeat (100) begin @(negedge clk); if (en) idle_en++; end
    chk("tp_off_en", idle_en, 0);
    chk("tp_off_amode", amode, 8'hFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
